// File: rtl/tap_test_access_ctrl_if.sv
// Pad-side bundle for the test access controller: serial config chain,
// injection nets, observation bus and capture readout.
// TAP_CFG_PARITY_EN adds the outCfgError signal.
interface tap_test_access_ctrl_if #(
   parameter int N_OBS = 8,
   parameter int OBS_W = 4,
   parameter int N_INJ = 8
);
   logic                   inCfgSerial, inCfgShift, inCfgUpdate, outCfgSerial;
   logic [N_OBS*OBS_W-1:0] inObsBus;
   logic [N_INJ-1:0]       inInjData, outInjEnable, outInjData;
   logic [OBS_W-1:0]       outObsData, outCapData;
   logic                   inCapStart, inCapRead, outCapValid, outCapDone, outBusy;
`ifdef TAP_CFG_PARITY_EN
   logic                   outCfgError;

   modport master (
      output inCfgSerial, inCfgShift, inCfgUpdate, inObsBus, inInjData, inCapStart, inCapRead,
      input  outCfgSerial, outInjEnable, outInjData, outObsData, outCapData, outCapValid,
             outCapDone, outBusy, outCfgError
   );
   modport slave (
      input  inCfgSerial, inCfgShift, inCfgUpdate, inObsBus, inInjData, inCapStart, inCapRead,
      output outCfgSerial, outInjEnable, outInjData, outObsData, outCapData, outCapValid,
             outCapDone, outBusy, outCfgError
   );
`else
   modport master (
      output inCfgSerial, inCfgShift, inCfgUpdate, inObsBus, inInjData, inCapStart, inCapRead,
      input  outCfgSerial, outInjEnable, outInjData, outObsData, outCapData, outCapValid,
             outCapDone, outBusy
   );
   modport slave (
      input  inCfgSerial, inCfgShift, inCfgUpdate, inObsBus, inInjData, inCapStart, inCapRead,
      output outCfgSerial, outInjEnable, outInjData, outObsData, outCapData, outCapValid,
             outCapDone, outBusy
   );
`endif
endinterface

// File: rtl/tap_test_access_ctrl.sv
// Test access controller for the MSK transceiver chain: serially loaded
// config, stimulus injection, live bus observation and a triggered capture
// buffer. Optional macro TAP_CFG_PARITY_EN appends an even-parity bit to the
// shift register and rejects updates that fail it (outCfgError pulse).
module tap_test_access_ctrl #(
   parameter int N_OBS     = 8,
   parameter int OBS_W     = 4,
   parameter int N_INJ     = 8,
   parameter int CAP_DEPTH = 16
) (
   input logic                   inClock,
   input logic                   inReset,
   tap_test_access_ctrl_if.slave tap
);
   localparam int SEL_W = $clog2(N_OBS);
   localparam int CFG_W = SEL_W + N_INJ + 2 + OBS_W;
   localparam int AW    = $clog2(CAP_DEPTH);
`ifdef TAP_CFG_PARITY_EN
   localparam int SR_W  = CFG_W + 1;
`else
   localparam int SR_W  = CFG_W;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   logic [SR_W-1:0]  shreg_q;
   logic [CFG_W-1:0] cfg_q;
   logic             cfg_load, new_mode1;
   logic [SEL_W-1:0] obs_sel;
   logic [N_INJ-1:0] inj_mask, inj_en_q, inj_dat_q;
   logic [1:0]       mode;
   logic [OBS_W-1:0] trig, sel_bus, obs_q, cap_dat_q;
   logic             cap_vld_q;
   state_t           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_en, rd_en;
   logic [OBS_W-1:0] mem_q [CAP_DEPTH];

   assign obs_sel   = cfg_q[SEL_W-1:0];
   assign inj_mask  = cfg_q[SEL_W +: N_INJ];
   assign mode      = cfg_q[SEL_W+N_INJ +: 2];
   assign trig      = cfg_q[SEL_W+N_INJ+2 +: OBS_W];
   assign new_mode1 = shreg_q[SEL_W+N_INJ+1];

`ifdef TAP_CFG_PARITY_EN
   logic cfg_err_q;
   // Whole word including the parity bit must XOR to zero to be accepted
   assign cfg_load = tap.inCfgUpdate & ~(^shreg_q);
   // One-cycle error flag for a rejected update
   always_ff @(posedge inClock or posedge inReset)
      if (inReset) cfg_err_q <= 1'b0;
      else         cfg_err_q <= tap.inCfgUpdate & (^shreg_q);
   assign tap.outCfgError = cfg_err_q;
`else
   assign cfg_load = tap.inCfgUpdate;
`endif

   // Serial config chain; update below sees the pre-shift contents
   always_ff @(posedge inClock or posedge inReset)
      if (inReset)              shreg_q <= '0;
      else if (tap.inCfgShift)  shreg_q <= {tap.inCfgSerial, shreg_q[SR_W-1:1]};

   // Active configuration
   always_ff @(posedge inClock or posedge inReset)
      if (inReset)       cfg_q <= '0;
      else if (cfg_load) cfg_q <= shreg_q[CFG_W-1:0];

   // Selected observable bus
   always_comb sel_bus = tap.inObsBus[obs_sel*OBS_W +: OBS_W];

   // Registered injection and observation paths
   always_ff @(posedge inClock or posedge inReset)
      if (inReset) begin
         inj_en_q  <= '0;
         inj_dat_q <= '0;
         obs_q     <= '0;
      end else begin
         inj_en_q  <= (mode != 2'b00) ? inj_mask : '0;
         inj_dat_q <= tap.inInjData & inj_mask;
         obs_q     <= sel_bus;
      end

   // Capture FSM state and pointers
   always_ff @(posedge inClock or posedge inReset)
      if (inReset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end

   // Capture FSM next state; a trigger match writes the matching sample
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      case (state_q)
         S_IDLE:    if (tap.inCapStart && mode[1]) state_d = S_ARMED;
         S_ARMED:
            if (!mode[0]) state_d = S_CAPTURE;
            else if (sel_bus == trig) begin
               wr_en   = 1'b1;
               state_d = S_CAPTURE;
            end
         S_CAPTURE: wr_en = 1'b1;
         S_DONE:    rd_en = tap.inCapRead;
         default:   state_d = S_IDLE;
      endcase
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == (AW+1)'(CAP_DEPTH-1)) state_d = S_DONE;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d    = cnt_q - 1'b1;
         if (rd_ptr_q == AW'(CAP_DEPTH-1)) state_d = S_IDLE;
      end
      // Leaving capture modes mid-operation abandons the capture
      if (cfg_load && !new_mode1 && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         wr_en    = 1'b0;
         rd_en    = 1'b0;
      end
   end

   // Capture storage, not reset
   always_ff @(posedge inClock)
      if (wr_en) mem_q[wr_ptr_q] <= sel_bus;

   // Readout register with one-cycle valid pulse
   always_ff @(posedge inClock or posedge inReset)
      if (inReset) begin
         cap_vld_q <= 1'b0;
         cap_dat_q <= '0;
      end else begin
         cap_vld_q <= rd_en;
         if (rd_en) cap_dat_q <= mem_q[rd_ptr_q];
      end

   assign tap.outCfgSerial = shreg_q[0];
   assign tap.outInjEnable = inj_en_q;
   assign tap.outInjData   = inj_dat_q;
   assign tap.outObsData   = obs_q;
   assign tap.outCapData   = cap_dat_q;
   assign tap.outCapValid  = cap_vld_q;
   assign tap.outCapDone   = (state_q == S_DONE);
   assign tap.outBusy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
endmodule

// File: tb/tb_tap_test_access_ctrl.sv
// Self-checking bench for tap_test_access_ctrl: reset, injection/observation,
// immediate and triggered capture, abort, and (with TAP_CFG_PARITY_EN) parity.
module tb_tap_test_access_ctrl;
   localparam int N_OBS = 8, OBS_W = 4, N_INJ = 8, CAP_DEPTH = 16;
   localparam int CFG_W = 3 + N_INJ + 2 + OBS_W;
`ifdef TAP_CFG_PARITY_EN
   localparam int SR_W = CFG_W + 1;
`else
   localparam int SR_W = CFG_W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0, bad = 0;

   // reference state: active config fields and current bus values
   logic [2:0]       m_sel;
   logic [N_INJ-1:0] m_mask;
   logic [1:0]       m_mode;
   logic [OBS_W-1:0] bus_m [N_OBS];

   tap_test_access_ctrl_if #(.N_OBS(N_OBS), .OBS_W(OBS_W), .N_INJ(N_INJ)) tif ();
   tap_test_access_ctrl #(.N_OBS(N_OBS), .OBS_W(OBS_W), .N_INJ(N_INJ), .CAP_DEPTH(CAP_DEPTH))
      dut (.inClock(clk), .inReset(rst), .tap(tif));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bus();
      for (int k = 0; k < N_OBS; k++) tif.inObsBus[k*OBS_W +: OBS_W] = bus_m[k];
   endtask

   task automatic rand_bus();
      for (int k = 0; k < N_OBS; k++) bus_m[k] = OBS_W'($urandom_range(0, 15));
      drive_bus();
   endtask

   // shift a config word LSB first; optionally pulse update and adopt it in the model
   task automatic load_cfg(input logic [2:0] sel, input logic [N_INJ-1:0] mask,
                           input logic [1:0] mode, input logic [OBS_W-1:0] trig,
                           input bit do_update, input bit bad_par);
      logic [CFG_W-1:0] w;
      logic [CFG_W:0]   sv;
      w  = {trig, mode, mask, sel};
      sv = {(^w) ^ bad_par, w};
      for (int i = 0; i < SR_W; i++) begin
         tif.inCfgSerial = sv[i];
         tif.inCfgShift  = 1'b1;
         tick();
      end
      tif.inCfgShift = 1'b0;
      if (do_update) begin
         tif.inCfgUpdate = 1'b1;
         tick();
         tif.inCfgUpdate = 1'b0;
         m_sel = sel; m_mask = mask; m_mode = mode;
      end
   endtask

   task automatic start_cap();
      tif.inCapStart = 1'b1;
      tick();
      tif.inCapStart = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++; if (tif.outInjEnable !== '0) begin bad++; $display("FAIL rst_inj_en: got %0h want 0", tif.outInjEnable); end
      total++; if (tif.outObsData !== '0) begin bad++; $display("FAIL rst_obs: got %0h want 0", tif.outObsData); end
      total++; if ({tif.outBusy, tif.outCapDone, tif.outCapValid, tif.outCfgSerial} !== 4'b0) begin
         bad++; $display("FAIL rst_flags: got %b want 0000", {tif.outBusy, tif.outCapDone, tif.outCapValid, tif.outCfgSerial}); end
      tick();
      rst = 1'b0;
      tick();
      // reset in the middle of an immediate capture
      rand_bus();
      load_cfg(3'd0, 8'h3C, 2'b10, 4'h0, 1'b1, 1'b0);
      start_cap();
      for (int i = 0; i < 6; i++) begin rand_bus(); tick(); end
      total++; if (tif.outBusy !== 1'b1) begin bad++; $display("FAIL mid_cap_busy: got %b want 1", tif.outBusy); end
      rst = 1'b1;
      #2;
      total++; if ({tif.outInjEnable, tif.outInjData, tif.outObsData, tif.outCapData} !== '0) begin
         bad++; $display("FAIL async_rst_data: got %0h want 0", {tif.outInjEnable, tif.outInjData, tif.outObsData, tif.outCapData}); end
      total++; if ({tif.outBusy, tif.outCapDone, tif.outCapValid} !== 3'b0) begin
         bad++; $display("FAIL async_rst_flags: got %b want 000", {tif.outBusy, tif.outCapDone, tif.outCapValid}); end
      tick();
      rst = 1'b0;
      m_sel = '0; m_mask = '0; m_mode = '0;
      tif.inCapRead = 1'b1; tick(); tif.inCapRead = 1'b0;
      total++; if (tif.outCapValid !== 1'b0) begin bad++; $display("FAIL rst_read_valid: got %b want 0", tif.outCapValid); end
      tick();
   endtask

   task automatic test_inject();
      logic [N_INJ-1:0] d;
      rand_bus();
      load_cfg(3'd3, 8'hA5, 2'b01, 4'h0, 1'b1, 1'b0);
      total++; if (tif.outCfgSerial !== 1'b1) begin bad++; $display("FAIL cfg_serial_out: got %b want 1", tif.outCfgSerial); end
      tif.inInjData = 8'hFF;
      bus_m[3] = 4'h9; drive_bus();
      tick();
      total++; if (tif.outInjEnable !== 8'hA5) begin bad++; $display("FAIL inj_en_dir: got %0h want a5", tif.outInjEnable); end
      total++; if (tif.outInjData !== 8'hA5) begin bad++; $display("FAIL inj_dat_dir: got %0h want a5", tif.outInjData); end
      total++; if (tif.outObsData !== 4'h9) begin bad++; $display("FAIL obs_dir: got %0h want 9", tif.outObsData); end
      for (int it = 0; it < 8; it++) begin
         load_cfg(3'($urandom_range(0, 7)), 8'($urandom), 2'($urandom_range(0, 3)), 4'($urandom), 1'b1, 1'b0);
         for (int c = 0; c < 3; c++) begin
            d = 8'($urandom);
            tif.inInjData = d;
            rand_bus();
            tick();
            total++; if (tif.outInjEnable !== ((m_mode != 2'b00) ? m_mask : 8'h00)) begin
               bad++; $display("FAIL inj_en_rand: got %0h want %0h", tif.outInjEnable, (m_mode != 2'b00) ? m_mask : 8'h00); end
            total++; if (tif.outInjData !== (d & m_mask)) begin
               bad++; $display("FAIL inj_dat_rand: got %0h want %0h", tif.outInjData, d & m_mask); end
            total++; if (tif.outObsData !== bus_m[m_sel]) begin
               bad++; $display("FAIL obs_rand: got %0h want %0h", tif.outObsData, bus_m[m_sel]); end
         end
      end
      tif.inInjData = '0;
   endtask

   // mode 10: armed on the start edge, capture state on the next, then one write per edge
   task automatic test_capture_imm();
      rand_bus();
      load_cfg(3'd0, 8'($urandom), 2'b10, 4'h0, 1'b1, 1'b0);
      start_cap();
      total++; if ({tif.outBusy, tif.outCapDone} !== 2'b10) begin bad++; $display("FAIL imm_armed: got %b want 10", {tif.outBusy, tif.outCapDone}); end
      for (int t = 1; t <= 17; t++) begin
         rand_bus();
         bus_m[0] = (t >= 2) ? OBS_W'(t - 2) : 4'hF;
         drive_bus();
         tick();
         if (t == 16) begin
            total++; if (tif.outCapDone !== 1'b0) begin bad++; $display("FAIL imm_done_early: got %b want 0", tif.outCapDone); end
         end
      end
      total++; if ({tif.outBusy, tif.outCapDone} !== 2'b01) begin bad++; $display("FAIL imm_done: got %b want 01", {tif.outBusy, tif.outCapDone}); end
      start_cap();
      total++; if ({tif.outBusy, tif.outCapDone} !== 2'b01) begin bad++; $display("FAIL imm_start_in_done: got %b want 01", {tif.outBusy, tif.outCapDone}); end
      for (int i = 0; i < CAP_DEPTH; i++) begin
         if (i == CAP_DEPTH - 1) begin
            total++; if (tif.outCapDone !== 1'b1) begin bad++; $display("FAIL imm_done_hold: got %b want 1", tif.outCapDone); end
         end
         tif.inCapRead = 1'b1; tick(); tif.inCapRead = 1'b0;
         total++; if ({tif.outCapValid, tif.outCapData} !== {1'b1, OBS_W'(i)}) begin
            bad++; $display("FAIL imm_read%0d: got v%b d%0h want v1 d%0h", i, tif.outCapValid, tif.outCapData, i); end
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            tick();
            total++; if (tif.outCapValid !== 1'b0) begin bad++; $display("FAIL imm_gap_valid: got %b want 0", tif.outCapValid); end
         end
      end
      total++; if ({tif.outBusy, tif.outCapDone} !== 2'b00) begin bad++; $display("FAIL imm_back_idle: got %b want 00", {tif.outBusy, tif.outCapDone}); end
      tif.inCapRead = 1'b1; tick(); tif.inCapRead = 1'b0;
      total++; if (tif.outCapValid !== 1'b0) begin bad++; $display("FAIL imm_idle_read: got %b want 0", tif.outCapValid); end
   endtask

   // mode 11: scoreboard queue starts at the sample equal to trig
   task automatic test_trigger();
      logic [OBS_W-1:0] exp_q[$];
      logic [OBS_W-1:0] seq[$];
      logic [OBS_W-1:0] v;
      logic [2:0]       sel;
      sel = 3'($urandom_range(0, 7));
      rand_bus(); bus_m[sel] = 4'h0; drive_bus();
      load_cfg(sel, 8'($urandom), 2'b11, 4'h7, 1'b1, 1'b0);
      start_cap();
      for (int i = $urandom_range(0, 3); i > 0; i--) begin
         do v = OBS_W'($urandom_range(0, 15)); while (v == 4'h7);
         seq.push_back(v);
      end
      seq.push_back(4'h1); seq.push_back(4'h3); seq.push_back(4'h7); seq.push_back(4'h2);
      for (int i = 0; i < 14; i++) seq.push_back(OBS_W'($urandom_range(0, 15)));
      foreach (seq[i]) begin
         if (exp_q.size() > 0 || seq[i] == 4'h7) exp_q.push_back(seq[i]);
         rand_bus(); bus_m[sel] = seq[i]; drive_bus();
         tick();
      end
      total++; if (tif.outCapDone !== 1'b1) begin bad++; $display("FAIL trig_done: got %b want 1", tif.outCapDone); end
      for (int i = 0; i < CAP_DEPTH; i++) begin
         tif.inCapRead = 1'b1; tick(); tif.inCapRead = 1'b0;
         v = exp_q.pop_front();
         total++; if ({tif.outCapValid, tif.outCapData} !== {1'b1, v}) begin
            bad++; $display("FAIL trig_read%0d: got v%b d%0h want v1 d%0h", i, tif.outCapValid, tif.outCapData, v); end
      end
      total++; if (tif.outCapDone !== 1'b0) begin bad++; $display("FAIL trig_idle: got %b want 0", tif.outCapDone); end
   endtask

   task automatic test_abort();
      logic [N_INJ-1:0] mask;
      mask = 8'($urandom) | 8'h01;
      rand_bus();
      load_cfg(3'd0, mask, 2'b10, 4'h0, 1'b1, 1'b0);
      load_cfg(3'd0, mask, 2'b00, 4'h0, 1'b0, 1'b0);
      start_cap();
      for (int i = 0; i < 5; i++) begin rand_bus(); tick(); end
      total++; if (tif.outBusy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", tif.outBusy); end
      tif.inCapRead = 1'b1;
      tif.inCfgUpdate = 1'b1; tick(); tif.inCfgUpdate = 1'b0;
      m_mode = 2'b00;
      total++; if ({tif.outBusy, tif.outCapDone} !== 2'b00) begin bad++; $display("FAIL abort_flags: got %b want 00", {tif.outBusy, tif.outCapDone}); end
      for (int i = 0; i < 18; i++) begin
         tick();
         if (tif.outCapDone !== 1'b0 || tif.outCapValid !== 1'b0) begin
            total++; bad++;
            $display("FAIL abort_after: got done%b valid%b want 0 0", tif.outCapDone, tif.outCapValid);
         end
      end
      tif.inCapRead = 1'b0;
      total++; if (tif.outCapValid !== 1'b0) begin bad++; $display("FAIL abort_read_valid: got %b want 0", tif.outCapValid); end
      total++; if (tif.outInjEnable !== 8'h00) begin bad++; $display("FAIL abort_inj_en: got %0h want 0", tif.outInjEnable); end
      start_cap();
      tick();
      total++; if (tif.outBusy !== 1'b0) begin bad++; $display("FAIL start_mode00: got %b want 0", tif.outBusy); end
   endtask

`ifdef TAP_CFG_PARITY_EN
   task automatic test_parity();
      load_cfg(3'd1, 8'h5A, 2'b01, 4'h0, 1'b0, 1'b0);
      tif.inCfgUpdate = 1'b1; tick(); tif.inCfgUpdate = 1'b0;
      total++; if (tif.outCfgError !== 1'b0) begin bad++; $display("FAIL par_good_err: got %b want 0", tif.outCfgError); end
      tick();
      total++; if (tif.outInjEnable !== 8'h5A) begin bad++; $display("FAIL par_good_en: got %0h want 5a", tif.outInjEnable); end
      load_cfg(3'd2, 8'hC3, 2'b01, 4'h0, 1'b0, 1'b1);
      tif.inCfgUpdate = 1'b1; tick(); tif.inCfgUpdate = 1'b0;
      total++; if (tif.outCfgError !== 1'b1) begin bad++; $display("FAIL par_bad_err: got %b want 1", tif.outCfgError); end
      tick();
      total++; if (tif.outCfgError !== 1'b0) begin bad++; $display("FAIL par_err_pulse: got %b want 0", tif.outCfgError); end
      total++; if (tif.outInjEnable !== 8'h5A) begin bad++; $display("FAIL par_bad_en: got %0h want 5a", tif.outInjEnable); end
   endtask
`endif

   initial begin
      tif.inCfgSerial = 1'b0; tif.inCfgShift = 1'b0; tif.inCfgUpdate = 1'b0;
      tif.inInjData = '0; tif.inCapStart = 1'b0; tif.inCapRead = 1'b0; tif.inObsBus = '0;
      for (int k = 0; k < N_OBS; k++) bus_m[k] = '0;
      m_sel = '0; m_mask = '0; m_mode = '0;
      test_reset();
      test_inject();
      test_capture_imm();
      test_trigger();
      test_abort();
`ifdef TAP_CFG_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tap_test_access_ctrl.md
Name: tap_test_access_ctrl

Overview:
Parametrised, registered successor to the static test mux/demux fabric around the MSK transceiver chain (inFIFO, coder, decoder, cordic, cdr, outFIFO).
- Pin-level select lines are replaced by a serially loaded configuration register.
- Provides stimulus injection on N_INJ internal 1-bit nets and a live registered view of one of N_OBS internal buses.
- Adds a triggered capture buffer that records the selected bus for later readout.
- Sits at top level between the pad ring and the datapath instances.

Parameters:
N_OBS, 8, number of observable buses (power of 2, >=2)
OBS_W, 4, width of each observable bus
N_INJ, 8, number of injectable 1-bit nets
CAP_DEPTH, 16, capture buffer depth (power of 2, >=4)
Derived (localparam, not overridable): SEL_W = clog2(N_OBS); CFG_W = SEL_W + N_INJ + 2 + OBS_W

Ports:
inClock  in  1  single system clock, rising edge
inReset  in  1  asynchronous, active-high reset
inCfgSerial  in  1  serial config data, LSB first
inCfgShift  in  1  shift enable for config shift register
inCfgUpdate  in  1  copy shift register into active config
outCfgSerial  out  1  shift register bit 0, for daisy-chaining
inObsBus  in  N_OBS*OBS_W  concatenated observable buses; bus k = [k*OBS_W +: OBS_W]
inInjData  in  N_INJ  stimulus values from pads
outInjEnable  out  N_INJ  per-net override enable
outInjData  out  N_INJ  registered stimulus values
outObsData  out  OBS_W  registered selected bus
inCapStart  in  1  arm capture (pulse)
inCapRead  in  1  pop one captured word
outCapData  out  OBS_W  read data
outCapValid  out  1  outCapData valid, one-cycle pulse
outCapDone  out  1  buffer full and readable
outBusy  out  1  FSM in ARMED or CAPTURE

Behaviour:
- Reset values: all outputs 0; shift register, active config, pointers and count 0; FSM IDLE.
- Config fields, LSB to MSB: obs_sel[SEL_W], inj_mask[N_INJ], mode[2], trig[OBS_W].
- mode encoding: 00 functional, 01 inject, 10 capture immediate, 11 capture on trigger.
- Shift: when inCfgShift=1, shreg <= {inCfgSerial, shreg[CFG_W-1:1]}.
- Update: when inCfgUpdate=1, active config <= shreg value as it stood before this cycle's shift. Shift and update in the same cycle are both honoured.
- Injection: outInjEnable <= (mode != 00) ? inj_mask : 0. outInjData <= inInjData & inj_mask. Latency 1 cycle.
- Observation: outObsData <= bus[obs_sel] every cycle. Latency 1 cycle.
- FSM states and transitions:
  - IDLE -> ARMED when inCapStart=1 and mode[1]=1. inCapStart with mode[1]=0 is ignored.
  - ARMED: mode 10 -> CAPTURE next cycle. Mode 11 -> CAPTURE in the cycle after bus[obs_sel]==trig; the matching sample is the first word written.
  - CAPTURE: writes bus[obs_sel] each cycle at wr_ptr. After CAP_DEPTH writes -> DONE.
  - DONE: outCapDone=1. inCapRead returns buf[rd_ptr] with outCapValid one cycle later and increments rd_ptr. After the CAP_DEPTH-th read -> IDLE and outCapDone=0.
- Reads outside DONE produce no outCapValid and do not move pointers.
- inCapStart during ARMED, CAPTURE or DONE is ignored.
- A config update that clears mode[1] while not in IDLE aborts to IDLE, clears pointers and count, and drops outCapDone; buffer contents are not cleared.
- obs_sel is always in range because N_OBS is a power of 2.

Optional Feature:
Macro TAP_CFG_PARITY_EN.
- Defined: shift register is CFG_W+1 bits; the MSB is an even-parity bit over the whole word. inCfgUpdate with bad parity leaves the active config unchanged and pulses extra output outCfgError (1 cycle, registered).
- Undefined: no parity bit and no outCfgError port.

Test Plan:
- Reset mid-capture (mode 10, 5 words written), then inReset=1 -> all outputs 0, FSM IDLE; a subsequent read produces no outCapValid.
- Shift 17 bits encoding obs_sel=3, inj_mask=0xA5, mode=01, trig=0; pulse update; inInjData=0xFF -> 1 cycle later outInjEnable=0xA5, outInjData=0xA5; bus3=0x9 -> outObsData=0x9.
- mode=10, obs_sel=0, bus0 incrementing 0..15, pulse inCapStart -> outCapDone after 16 captures; 16 reads return 0..15 in order, each with outCapValid one cycle later; FSM back to IDLE.
- mode=11, trig=0x7, bus driven 0x1,0x3,0x7,0x2 -> first captured word is 0x7, second 0x2.
- During CAPTURE, update config to mode=00 -> outBusy=0 next cycle, outCapDone stays 0; inCapRead yields no valid.
- With TAP_CFG_PARITY_EN: shift word with wrong parity and update -> outCfgError pulses once; outInjEnable unchanged.
